hilo_mult_unit: RTL and testbench

- Sits directly downstream of ALU control in the EX stage. Consumes ALUCtl, HiLoWrite and the two register operands.
- Executes the HI/LO-class instructions: mult, multu, madd, msub, mul, mthi, mtlo. Owns the architectural Hi and Lo registers.
- Multiplies are iterative and multi-cycle. The block stalls the pipeline while busy and presents Hi/Lo to the ALU for mfhi/mflo.

---
 rtl/hilo_pkg.sv | 18 +
 rtl/hilo_mult_unit_if.sv | 18 +
 rtl/hilo_mult_unit_mult_core.sv | 44 ++++
 rtl/hilo_mult_unit.sv | 77 +++++++
 tb/tb_hilo_mult_unit.sv | 134 +++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared ALUCtl opcodes, FSM state type and default width for the HI/LO unit
// Also the source of opcode values for ALU control (multu lives at 01110).
package hilo_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MADD  = 5'b01100;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MULTU = 5'b01110;
  localparam logic [4:0] OP_MUL   = 5'b11000;
  localparam logic [4:0] OP_MFHI  = 5'b10000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MFLO  = 5'b10010;
  localparam logic [4:0] OP_MTLO  = 5'b10011;
  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_t;
  function automatic logic is_hilo(input logic [4:0] op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_MULTU, OP_MUL, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO};
  endfunction
endpackage

// File: rtl/hilo_mult_unit_if.sv
// hilo_mult_unit_if: EX-stage request/response bundle between the pipeline and the HI/LO unit
// master (pipeline): drives Start, HiLoWrite, ALUCtl, A, B; sees Stall, Busy, Done, MulResult, Hi, Lo.
// slave (HI/LO unit): the reverse.
interface hilo_mult_unit_if #(parameter int DATA_WIDTH = hilo_pkg::DATA_WIDTH);
  logic                  Start;
  logic                  HiLoWrite;
  logic [4:0]            ALUCtl;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  Stall;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] MulResult;
  logic [DATA_WIDTH-1:0] Hi;
  logic [DATA_WIDTH-1:0] Lo;
  modport master (output Start, HiLoWrite, ALUCtl, A, B, input Stall, Busy, Done, MulResult, Hi, Lo);
  modport slave (input Start, HiLoWrite, ALUCtl, A, B, output Stall, Busy, Done, MulResult, Hi, Lo);
endinterface

// File: rtl/hilo_mult_unit_mult_core.sv
// mult_core: iterative unsigned shift-add multiplier retiring BPC multiplier bits per cycle
// Ports: Clk, Rst (async active-low); start loads a/b and clears acc/counter;
// run advances one step; prod is the accumulator; last flags the final step.
module mult_core #(
  parameter int W = 32,
  parameter int BPC = 1
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           start,
  input  logic           run,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           last
);
  localparam int N = W / BPC;
  localparam int CW = $clog2(N);
  logic [CW-1:0] cnt;
  logic [2*W-1:0] mcand, pp;
  logic [W-1:0] mpl;
  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++) pp = pp + (mpl[i] ? mcand << i : '0);
  end
  assign last = run && cnt == CW'(N - 1);
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      prod <= '0;
      mcand <= '0;
      mpl <= '0;
      cnt <= '0;
    end else if (start) begin
      prod <= '0;
      mcand <= {{W{1'b0}}, a};
      mpl <= b;
      cnt <= '0;
    end else if (run) begin
      prod <= prod + pp;
      mcand <= mcand << BPC;
      mpl <= mpl >> BPC;
      cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: EX-stage HI/LO unit (mult/multu/madd/msub/mul/mthi/mtlo) owning Hi and Lo
// Ports: Clk, Rst (async active-low), bus (hilo_mult_unit_if.slave) carrying the
// request (Start, HiLoWrite, ALUCtl, A, B) and response (Stall, Busy, Done, MulResult, Hi, Lo).
module hilo_mult_unit
  import hilo_pkg::*;
#(
  parameter int DATA_WIDTH = hilo_pkg::DATA_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic Clk,
  input logic Rst,
  hilo_mult_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;
  state_t state;
  logic [4:0] op;
  logic neg, sgn, accept, go, last, done;
  logic [W-1:0] ma, mb, hi, lo, mul_res;
  logic [2*W-1:0] prod, fixed, res;
  assign accept = bus.Start && state == IDLE;
  assign go = accept && ((bus.ALUCtl == OP_MUL) || (bus.HiLoWrite && (bus.ALUCtl inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB})));
  // The core is unsigned; signed ops feed magnitudes and fix the sign afterwards.
  assign sgn = bus.ALUCtl != OP_MULTU;
  assign ma = (sgn && bus.A[W-1]) ? -bus.A : bus.A;
  assign mb = (sgn && bus.B[W-1]) ? -bus.B : bus.B;
  assign fixed = neg ? -prod : prod;
  assign bus.Stall = bus.Start && state != IDLE && is_hilo(bus.ALUCtl);
  assign bus.Busy = state != IDLE;
  assign bus.Done = done;
  assign bus.MulResult = mul_res;
  assign bus.Hi = hi;
  assign bus.Lo = lo;
  mult_core #(.W(W), .BPC(BITS_PER_CYCLE)) core (
    .Clk(Clk),
    .Rst(Rst),
    .start(go),
    .run(state == CALC),
    .a(ma),
    .b(mb),
    .prod(prod),
    .last(last)
  );
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= IDLE;
      op <= '0;
      neg <= 1'b0;
      res <= '0;
      hi <= '0;
      lo <= '0;
      mul_res <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (go) begin
            op <= bus.ALUCtl;
            neg <= sgn && (bus.A[W-1] ^ bus.B[W-1]);
            state <= CALC;
          end else if (accept && bus.HiLoWrite && bus.ALUCtl == OP_MTHI) hi <= bus.A;
          else if (accept && bus.HiLoWrite && bus.ALUCtl == OP_MTLO) lo <= bus.A;
        CALC: if (last) state <= FIX;
        FIX: begin
          res <= op == OP_MADD ? {hi, lo} + fixed : op == OP_MSUB ? {hi, lo} - fixed : fixed;
          state <= WRITE;
        end
        WRITE: begin
          done <= 1'b1;
          if (op == OP_MUL) mul_res <= res[W-1:0];
          else {hi, lo} <= res;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: directed self-checking bench for hilo_mult_unit
module tb_hilo_mult_unit;
  import hilo_pkg::*;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_BAD = 5'b11111;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  hilo_mult_unit_if #(.DATA_WIDTH(32)) bus ();
  hilo_mult_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) dut (.Clk(clk), .Rst(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] op, input logic hw, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.ALUCtl = op;
    bus.HiLoWrite = hw;
    bus.A = a;
    bus.B = b;
    step();
    bus.Start = 1'b0;
  endtask
  task automatic move(input string tag, input logic [4:0] op, input logic [31:0] a);
    drive(op, 1'b1, a, 32'd0);
    chk({tag, "_busy"}, 64'(bus.Busy), 64'd0);
  endtask
  task automatic run(input string tag, input logic [4:0] op, input logic hw, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic [31:0] exp_mr);
    int cyc = 0;
    drive(op, hw, a, b);
    while (!bus.Done && cyc < 100) begin
      step();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd34);
    if (op == OP_MUL) chk({tag, "_mr"}, 64'(bus.MulResult), 64'(exp_mr));
    step();
    chk({tag, "_done_low"}, 64'(bus.Done), 64'd0);
    chk({tag, "_hi"}, 64'(bus.Hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.Lo), 64'(exp_lo));
  endtask
  initial begin
    int cyc, bad_stall, bad_hi, dones;
    bus.Start = 1'b0;
    bus.HiLoWrite = 1'b0;
    bus.ALUCtl = '0;
    bus.A = '0;
    bus.B = '0;
    #12;
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_stall", 64'(bus.Stall), 64'd0);
    chk("rst_hi", 64'(bus.Hi), 64'd0);
    chk("rst_lo", 64'(bus.Lo), 64'd0);
    chk("rst_mr", 64'(bus.MulResult), 64'd0);
    rst_n = 1'b1;
    step();
    run("mult_neg", OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'd0);
    run("multu_max", OP_MULTU, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'd0);
    move("mtlo", OP_MTLO, 32'h10);
    chk("mtlo_lo", 64'(bus.Lo), 64'h10);
    move("mthi", OP_MTHI, 32'h0);
    chk("mthi_hi", 64'(bus.Hi), 64'h0);
    run("madd", OP_MADD, 1'b1, 32'd2, 32'd3, 32'h0, 32'h16, 32'd0);
    move("mtlo5", OP_MTLO, 32'h5);
    move("mthi0", OP_MTHI, 32'h0);
    run("msub", OP_MSUB, 1'b1, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    move("mthi_a", OP_MTHI, 32'hAAAA5555);
    move("mtlo_a", OP_MTLO, 32'hAAAA5555);
    run("mul", OP_MUL, 1'b0, 32'd7, 32'hFFFFFFFE, 32'hAAAA5555, 32'hAAAA5555, 32'hFFFFFFF2);
    drive(OP_MULT, 1'b1, 32'd3, 32'd4);
    bus.Start = 1'b1;
    bus.ALUCtl = OP_ADD;
    bus.HiLoWrite = 1'b0;
    #1;
    chk("add_no_stall", 64'(bus.Stall), 64'd0);
    bus.ALUCtl = OP_MFHI;
    #1;
    cyc = 0;
    bad_stall = 0;
    bad_hi = 0;
    while (bus.Busy && cyc < 100) begin
      if (!bus.Stall) bad_stall++;
      if (bus.Hi !== 32'hAAAA5555) bad_hi++;
      step();
      cyc++;
    end
    chk("busy_cycles", 64'(cyc), 64'd34);
    chk("mfhi_stalled", 64'(bad_stall), 64'd0);
    chk("hi_frozen", 64'(bad_hi), 64'd0);
    chk("stall_done", 64'(bus.Done), 64'd1);
    chk("stall_drop", 64'(bus.Stall), 64'd0);
    chk("stall_hi", 64'(bus.Hi), 64'd0);
    chk("stall_lo", 64'(bus.Lo), 64'd12);
    bus.Start = 1'b0;
    step();
    drive(OP_MULT, 1'b1, 32'd9, 32'd9);
    repeat (10) step();
    chk("mid_busy", 64'(bus.Busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.Busy), 64'd0);
    chk("arst_hi", 64'(bus.Hi), 64'd0);
    chk("arst_lo", 64'(bus.Lo), 64'd0);
    step();
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      if (bus.Done || bus.Busy) dones++;
      step();
    end
    chk("arst_no_done", 64'(dones), 64'd0);
    run("mult_6x7", OP_MULT, 1'b1, 32'd6, 32'd7, 32'h0, 32'd42, 32'd0);
    drive(OP_BAD, 1'b1, 32'h1234, 32'h5678);
    chk("bad_busy", 64'(bus.Busy), 64'd0);
    chk("bad_hi", 64'(bus.Hi), 64'h0);
    chk("bad_lo", 64'(bus.Lo), 64'd42);
    run("min_sq", OP_MULT, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 32'd0);
    run("min_x1", OP_MULT, 1'b1, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run("zero", OP_MULT, 1'b1, 32'd0, 32'd5, 32'h0, 32'h0, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
